// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU round-robin scheduler
//   alu_op_e      - ALU opcodes (OP_MUL returns two result words)
//   alu_movi_e    - operand-B source select
//   sched_state_e - scheduler FSM states
package alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD = 4'b0000, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL,
      OP_SHR, OP_SRA, OP_ROL, OP_ROR, OP_MOV, OP_CMP, OP_INC, OP_DEC
   } alu_op_e;
   typedef enum logic [1:0] {REG = 2'b00, MEM = 2'b01, IMM = 2'b10} alu_movi_e;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WAIT_HI, RESP} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req - request vector      ptr - highest-priority index   en  - grant enable
//   gnt - one-hot grant       id  - encoded index of the grant
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  id
);
   // Scan from the farthest offset down so the nearest request after ptr wins last.
   always_comb begin
      id = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % NREQ]) id = IDW'((int'(ptr) + i) % NREQ);
      gnt = (en && |req) ? NREQ'(1) << id : '0;
   end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one ALU among NREQ requesters, round-robin, one op in flight
//   CLK/RST                        clock, synchronous active-high reset
//   req_valid/req_ready            per-requester handshake (ready one-hot, IDLE only)
//   req_op/movi/a/b/mem/imm        per-requester packed fields, slice i per requester
//   alu_act/op/movi/reg_a/reg_b/mem/imm  ALU command, held from ISSUE through WAIT_HI
//   alu_rdy/alu_vld/alu_data       ALU status and result words
//   rsp_valid/ready/id/data/err    64-bit response, {hi,lo} for mul
// Optional: ALU_RR_SCHEDULER_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on the ALU result.
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_op,
   input  logic [2*NREQ-1:0] req_movi,
   input  logic [32*NREQ-1:0] req_a,
   input  logic [32*NREQ-1:0] req_b,
   input  logic [32*NREQ-1:0] req_mem,
   input  logic [32*NREQ-1:0] req_imm,
   output logic              alu_act,
   output logic [3:0]        alu_op,
   output logic [1:0]        alu_movi,
   output logic [31:0]       alu_reg_a,
   output logic [31:0]       alu_reg_b,
   output logic [31:0]       alu_mem,
   output logic [31:0]       alu_imm,
   input  logic              alu_rdy,
   input  logic              alu_vld,
   input  logic [31:0]       alu_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [63:0]       rsp_data,
   output logic              rsp_err
);
   sched_state_e state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt_id;
   logic [NREQ-1:0] gnt;
   logic [3:0] op_q, op_d;
   logic [1:0] movi_q, movi_d;
   logic [31:0] a_q, a_d, b_q, b_d, mem_q, mem_d, imm_q, imm_d, lo_q, lo_d, hi_q, hi_d;
   logic busy;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
`endif
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .en  (state_q == IDLE),
      .gnt (gnt),
      .id  (gnt_id)
   );
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      movi_d  = movi_q;
      a_d     = a_q;
      b_d     = b_q;
      mem_d   = mem_q;
      imm_d   = imm_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: if (|req_valid) begin
            state_d = ISSUE;
            id_d    = gnt_id;
            ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            op_d    = req_op[4*gnt_id +: 4];
            movi_d  = req_movi[2*gnt_id +: 2];
            a_d     = req_a[32*gnt_id +: 32];
            b_d     = req_b[32*gnt_id +: 32];
            mem_d   = req_mem[32*gnt_id +: 32];
            imm_d   = req_imm[32*gnt_id +: 32];
            lo_d    = '0;
            hi_d    = '0;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         ISSUE: if (alu_rdy) begin
            state_d = WAIT;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: if (alu_vld) begin
            lo_d    = alu_data;
            state_d = (op_q == OP_MUL) ? WAIT_HI : RESP;
         end
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
         // Give up after TIMEOUT silent cycles; data was cleared at grant.
         else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = RESP;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
`endif
         WAIT_HI: begin
            state_d = RESP;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
            hi_d    = alu_vld ? alu_data : '0;
            err_d   = !alu_vld;
`else
            hi_d    = alu_data;
`endif
         end
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         op_q    <= '0;
         movi_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mem_q   <= '0;
         imm_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         movi_q  <= movi_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mem_q   <= mem_d;
         imm_q   <= imm_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end
   // ALU command is only visible while an operation is in flight.
   assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WAIT_HI);
   assign req_ready = gnt;
   assign alu_act   = (state_q == ISSUE) && alu_rdy;
   assign alu_op    = busy ? op_q   : '0;
   assign alu_movi  = busy ? movi_q : '0;
   assign alu_reg_a = busy ? a_q    : '0;
   assign alu_reg_b = busy ? b_q    : '0;
   assign alu_mem   = busy ? mem_q  : '0;
   assign alu_imm   = busy ? imm_q  : '0;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_valid ? id_q : '0;
   assign rsp_data  = rsp_valid ? {hi_q, lo_q} : '0;
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
   assign rsp_err   = rsp_valid && err_q;
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = 32'(TIMEOUT);
   assign rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed vector table plus hand-written multi-cycle sequences
module tb_alu_rr_scheduler;
   localparam int NREQ = 4;
   localparam int IDW = 2;
   localparam int TIMEOUT = 8;
   logic CLK, RST;
   logic [NREQ-1:0] req_valid, req_ready;
   logic [4*NREQ-1:0] req_op;
   logic [2*NREQ-1:0] req_movi;
   logic [32*NREQ-1:0] req_a, req_b, req_mem, req_imm;
   logic alu_act, alu_rdy, alu_vld, rsp_valid, rsp_ready, rsp_err;
   logic [3:0] alu_op;
   logic [1:0] alu_movi;
   logic [31:0] alu_reg_a, alu_reg_b, alu_mem, alu_imm, alu_data;
   logic [IDW-1:0] rsp_id;
   logic [63:0] rsp_data;
   logic alu_mute, hi_pend;
   logic [31:0] hi_word;
   logic [63:0] res;
   int checks = 0, errors = 0;
   typedef struct {
      int r;
      logic [3:0] op;
      logic [1:0] movi;
      logic [31:0] a, b, mem, imm;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[7];
   alu_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_movi(req_movi),
      .req_a(req_a), .req_b(req_b), .req_mem(req_mem), .req_imm(req_imm),
      .alu_act(alu_act), .alu_op(alu_op), .alu_movi(alu_movi),
      .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b), .alu_mem(alu_mem), .alu_imm(alu_imm),
      .alu_rdy(alu_rdy), .alu_vld(alu_vld), .alu_data(alu_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   // Behavioural ALU: lo word the cycle after act, hi word the cycle after that for mul.
   function automatic logic [63:0] alu_fn(logic [3:0] op, logic [1:0] mv,
                                          logic [31:0] a, logic [31:0] b,
                                          logic [31:0] m, logic [31:0] i);
      logic [31:0] y;
      y = (mv == 2'b01) ? m : (mv == 2'b10) ? i : b;
      case (op)
         4'h0: return {32'b0, a + y};
         4'h1: return {32'b0, a - y};
         4'h2: return {32'b0, a} * {32'b0, y};
         4'h3: return {32'b0, a & y};
         4'h5: return {32'b0, a ^ y};
         default: return 64'b0;
      endcase
   endfunction
   assign res = alu_fn(alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm);
   always @(posedge CLK) begin
      if (RST) begin
         alu_vld <= 1'b0; alu_data <= '0; hi_pend <= 1'b0; hi_word <= '0;
      end else if (alu_act && !alu_mute) begin
         alu_vld <= 1'b1; alu_data <= res[31:0]; hi_word <= res[63:32];
         hi_pend <= (alu_op == 4'h2);
      end else if (hi_pend) begin
         alu_vld <= 1'b1; alu_data <= hi_word; hi_pend <= 1'b0;
      end else begin
         alu_vld <= 1'b0; alu_data <= '0;
      end
   end
   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic set_req(int r, logic [3:0] op, logic [1:0] mv, logic [31:0] a,
                          logic [31:0] b, logic [31:0] m, logic [31:0] i);
      req_op[4*r +: 4] = op;
      req_movi[2*r +: 2] = mv;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_mem[32*r +: 32] = m;
      req_imm[32*r +: 32] = i;
   endtask
   task automatic cyc();
      @(negedge CLK);
   endtask
   task automatic settle();
      #1;
   endtask
   task automatic run_vec(vec_t v);
      cyc();
      set_req(v.r, v.op, v.movi, v.a, v.b, v.mem, v.imm);
      req_valid = '0;
      req_valid[v.r] = 1'b1;
      settle();
      check("vec_grant", 64'(req_ready), 64'(4'b1 << v.r));
      cyc();
      req_valid = '0;
      settle();
      check("vec_act", 64'(alu_act), 64'd1);
      check("vec_alu_op", 64'(alu_op), 64'(v.op));
      check("vec_alu_movi", 64'(alu_movi), 64'(v.movi));
      check("vec_alu_a", 64'(alu_reg_a), 64'(v.a));
      cyc();
      settle();
      check("vec_no_rsp_t2", 64'(rsp_valid), 64'd0);
      check("vec_act_once", 64'(alu_act), 64'd0);
      if (v.op == 4'h2) begin
         cyc();
         settle();
         check("vec_no_rsp_t3_mul", 64'(rsp_valid), 64'd0);
      end
      cyc();
      settle();
      check("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      check("vec_rsp_id", 64'(rsp_id), 64'(v.r));
      check("vec_rsp_data", rsp_data, v.exp);
      check("vec_rsp_err", 64'(rsp_err), 64'd0);
      check("vec_alu_idle_in_resp", 64'(alu_op) | 64'(alu_reg_a), 64'd0);
      cyc();
      settle();
      check("vec_rsp_drop", 64'(rsp_valid), 64'd0);
   endtask
   function automatic int idx_of(logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction
   initial begin
      int exp_rr[5];
      int n, k;
      logic seen;
      vecs[0] = '{0, 4'h0, 2'b00, 32'd5, 32'd3, 32'd0, 32'd0, 64'd8};
      vecs[1] = '{2, 4'h2, 2'b00, 32'h10000, 32'h10000, 32'd0, 32'd0, 64'h1_0000_0000};
      vecs[2] = '{1, 4'h1, 2'b01, 32'd10, 32'd99, 32'd4, 32'd0, 64'd6};
      vecs[3] = '{3, 4'h3, 2'b10, 32'h0000F0F0, 32'd0, 32'd0, 32'h00000FF0, 64'h00F0};
      vecs[4] = '{1, 4'h5, 2'b11, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 32'd0, 64'hF0F00F0F};
      vecs[5] = '{0, 4'h2, 2'b00, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 64'h1_FFFF_FFFE};
      vecs[6] = '{3, 4'h0, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 64'h0};
      exp_rr = '{0, 1, 2, 3, 0};
      RST = 1'b1; req_valid = '0; req_op = '0; req_movi = '0;
      req_a = '0; req_b = '0; req_mem = '0; req_imm = '0;
      alu_rdy = 1'b1; rsp_ready = 1'b1; alu_mute = 1'b0;
      repeat (2) cyc();
      settle();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_alu_act", 64'(alu_act), 64'd0);
      check("rst_alu_op", 64'(alu_op), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      RST = 1'b0;
      foreach (vecs[i]) run_vec(vecs[i]);
      // All requesters busy: pointer is 0 after the last vector granted requester 3.
      for (int i = 0; i < NREQ; i++) set_req(i, 4'h0, 2'b00, 32'(i), 32'd0, 32'd0, 32'd0);
      cyc();
      req_valid = '1;
      n = 0;
      for (int c = 0; c < 100 && n < 5; c++) begin
         settle();
         if (|req_ready) begin
            check("rr_order", 64'(idx_of(req_ready)), 64'(exp_rr[n]));
            n++;
         end
         if (n < 5) cyc();
      end
      check("rr_budget", 64'(n), 64'd5);
      cyc();
      req_valid = '0;
      repeat (8) cyc();
      // Response back-pressure with requester 1 still asking.
      set_req(1, 4'h0, 2'b00, 32'd7, 32'd8, 32'd0, 32'd0);
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         settle();
         seen = rsp_valid;
         if (!seen) cyc();
      end
      check("bp_rsp_seen", 64'(seen), 64'd1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin cyc(); settle(); end
         check("bp_rsp_hold", 64'(rsp_valid), 64'd1);
         check("bp_rsp_data", rsp_data, 64'd15);
         check("bp_no_grant", 64'(req_ready), 64'd0);
      end
      cyc();
      rsp_ready = 1'b1;
      settle();
      check("bp_consume", 64'(rsp_valid), 64'd1);
      cyc();
      settle();
      check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
      check("bp_regrant", 64'(req_ready), 64'b0010);
      cyc();
      req_valid = '0;
      repeat (8) cyc();
      // ALU busy for 3 cycles in ISSUE.
      alu_rdy = 1'b0;
      set_req(2, 4'h1, 2'b00, 32'd9, 32'd4, 32'd0, 32'd0);
      req_valid = 4'b0100;
      settle();
      check("stall_grant", 64'(req_ready), 64'b0100);
      for (int c = 0; c < 3; c++) begin
         cyc();
         req_valid = '0;
         settle();
         check("stall_no_act", 64'(alu_act), 64'd0);
         check("stall_op_held", 64'(alu_op), 64'd1);
      end
      cyc();
      alu_rdy = 1'b1;
      settle();
      check("stall_act", 64'(alu_act), 64'd1);
      cyc();
      settle();
      check("stall_act_pulse", 64'(alu_act), 64'd0);
      cyc();
      settle();
      check("stall_rsp", rsp_data, 64'd5);
      check("stall_rsp_id", 64'(rsp_id), 64'd2);
      repeat (2) cyc();
      // Reset in WAIT aborts the operation; pointer returns to 0.
      set_req(0, 4'h0, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0);
      req_valid = 4'b0001;
      settle();
      check("rst_op_grant", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      cyc();
      RST = 1'b1;
      cyc();
      settle();
      check("rst_mid_act", 64'(alu_act), 64'd0);
      check("rst_mid_op", 64'(alu_reg_a), 64'd0);
      check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
      RST = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         settle();
         seen = seen | rsp_valid;
      end
      check("rst_no_rsp", 64'(seen), 64'd0);
      cyc();
      req_valid = 4'b0011;
      settle();
      check("rst_ptr_zero", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      repeat (8) cyc();
`ifdef ALU_RR_SCHEDULER_TIMEOUT_EN
      alu_mute = 1'b1;
      set_req(1, 4'h0, 2'b00, 32'd3, 32'd3, 32'd0, 32'd0);
      req_valid = 4'b0010;
      cyc();
      req_valid = '0;
      settle();
      check("to_act", 64'(alu_act), 64'd1);
      k = 0;
      seen = 1'b0;
      for (int c = 1; c < 40 && !seen; c++) begin
         cyc();
         settle();
         seen = rsp_valid;
         k = c;
      end
      check("to_latency", 64'(k), 64'(TIMEOUT + 1));
      check("to_err", 64'(rsp_err), 64'd1);
      check("to_data", rsp_data, 64'd0);
      alu_mute = 1'b0;
      repeat (3) cyc();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one ALU instance among NREQ requesters using round-robin arbitration.
- Accepts one operation at a time, sequences the ALU ACT/RDY/VLD protocol, and holds operands stable for the whole operation.
- Collects the single-word result, or the low and high words of a multiply, into one 64-bit response tagged with the requester id.
- Sits between the issue stages of the requesters and the shared ALU.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester id.
- TIMEOUT, 8, cycles allowed from ACT to the first VLD (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle; one-hot or zero.
- req_op  in  4*NREQ  opcode per requester (slice i = bits 4i+3:4i).
- req_movi  in  2*NREQ  operand-B select per requester.
- req_a, req_b, req_mem, req_imm  in  32*NREQ each  operands per requester.
- alu_act  out  1  ALU start strobe.
- alu_op  out  4  opcode to the ALU.
- alu_movi  out  2  operand-B select to the ALU.
- alu_reg_a, alu_reg_b, alu_mem, alu_imm  out  32 each  operands to the ALU.
- alu_rdy  in  1  ALU idle.
- alu_vld  in  1  ALU result word valid.
- alu_data  in  32  ALU result word.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  IDW  id of the requester that issued the operation.
- rsp_data  out  64  result; {hi, lo} for mul, {32'b0, word} otherwise.
- rsp_err  out  1  operation timed out.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, captured registers cleared.
- Reset mid-operation aborts immediately. No response is produced. The ALU shares RST.
- States:
  - IDLE
    - If any req_valid is set: grant the first requester at or after the pointer (wrapping), pulse its req_ready for 1 cycle, latch its op/movi/operands/id, set pointer = grant+1 mod NREQ.
    - Go to ISSUE.
  - ISSUE
    - Drive the latched fields onto the alu_* outputs.
    - alu_act = alu_rdy. While alu_rdy = 0, stay in ISSUE with alu_act low.
    - When alu_act = 1 (one cycle only), go to WAIT.
  - WAIT
    - First cycle with alu_vld = 1: capture alu_data as lo.
    - Op 4'b0010 (mul): go to WAIT_HI. Any other op: go to RESP.
  - WAIT_HI
    - Next cycle's alu_data is captured as hi. alu_vld must be 1 in that cycle.
    - Go to RESP.
  - RESP
    - rsp_valid = 1; rsp_id/rsp_data stay stable until rsp_ready.
    - On rsp_ready = 1, return to IDLE. rsp_valid deasserts the next cycle.
- alu_* outputs hold the latched values from ISSUE through WAIT_HI. They are 0 in IDLE and RESP.
- Latency: req accept at T, alu_act at T+1 (if alu_rdy = 1), first VLD at T+2.
  - Non-mul: rsp_valid at T+3.
  - Mul: rsp_valid at T+4.
- Single outstanding operation. No grant while busy; req_ready stays 0 outside IDLE.
- Requester obligation: keep req fields stable while req_valid is high and req_ready is low.
- Single requester: it is granted back-to-back, with a minimum spacing of 4 cycles (5 for mul) plus the response stall.
- alu_movi = 2'b11 is passed through unchanged. It is not treated as an error.
- rsp_err = 0 whenever the optional feature is absent.

Optional Feature:
- Macro: ALU_RR_SCHEDULER_TIMEOUT_EN.
- When defined:
  - A counter starts at alu_act.
  - If TIMEOUT cycles elapse in WAIT with no alu_vld, go to RESP with rsp_err = 1 and rsp_data = 0.
  - A missing VLD in WAIT_HI also gives rsp_err = 1, with lo kept and hi = 0.
- When not defined: no counter, WAIT waits forever, and rsp_err is tied to 0.

Decomposition:
- Package alu_pkg holds:
  - Opcode enum alu_op_e, with OP_ADD = 4'b0000 through OP_DEC = 4'b1111 and OP_MUL = 4'b0010.
  - Operand-B select enum alu_movi_e: REG = 00, MEM = 01, IMM = 10.
  - Scheduler state enum sched_state_e: IDLE, ISSUE, WAIT, WAIT_HI, RESP.
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded id.
  - Pure combinational.

Test Plan:
- Reset, then req0 add with a = 5, b = 3, movi = 00, alu_rdy = 1 -> req_ready[0] at T, alu_act at T+1 with alu_op = 0000, rsp_valid at T+3 with rsp_id = 0.
- req2 mul with a = 0x10000, b = 0x10000; the ALU model returns lo = 0x0 and hi = 0x1 -> rsp_data = 64'h1_0000_0000 at T+4, rsp_id = 2.
- All four requesters valid continuously, rsp_ready = 1 -> grants occur in order 0, 1, 2, 3, 0. No requester is granted twice before the others.
- rsp_ready held low for 5 cycles -> rsp_valid/rsp_data stable throughout, req_ready stays 0, next grant comes 1 cycle after the response is consumed.
- alu_rdy low for 3 cycles in ISSUE -> alu_act stays low, then pulses for exactly 1 cycle. RST asserted in WAIT -> all outputs 0 next cycle, no response.
- With ALU_RR_SCHEDULER_TIMEOUT_EN and alu_vld never set -> rsp_valid with rsp_err = 1 and rsp_data = 0 at act + TIMEOUT + 1.
